hazard_scoreboard: RTL

Parametrised successor to the fixed 3-deep MIPS hazard detector. It decodes the instruction in decode and tracks destination registers of in-flight writers in a DEPTH-stage shift scoreboard. It raises a registered stall when a source operand depends on an in-flight write. An optional forwarding mode stalls only on load-use, and the block adds flush, valid qualification, hazard-register reporting and a saturating stall counter. It sits beside the decode stage and drives the fetch/decode hold and bubble insertion.

---
 rtl/hazard_scoreboard.sv | 104 ++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard detector: tracks in-flight destination registers in a
// DEPTH-stage shift scoreboard and raises a registered stall on RAW dependencies.
module hazard_scoreboard #(
  parameter int REG_W  = 5,
  parameter int DEPTH  = 3,
  parameter int FWD_EN = 0,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr_in,
  input  logic             valid_in,
  input  logic             flush_in,
  output logic             stall_out,
  output logic [REG_W-1:0] hazard_reg_out,
  output logic [CNT_W-1:0] stall_count_out
);

  logic [REG_W-1:0] stage_dest [DEPTH];
  logic [DEPTH-1:0] stage_ld;

  logic [5:0]       op;
  logic [REG_W-1:0] rs, rt, rd;
  logic             rd_rs, rd_rt, wr_en, is_ld;
  logic [REG_W-1:0] wr_dst;
  logic             rs_hit, rt_hit, tracked, stall_nxt;
  logic [REG_W-1:0] haz_nxt;
  logic             unused_instr;

  assign op = instr_in[31:26];
  assign rs = instr_in[21 +: REG_W];
  assign rt = instr_in[16 +: REG_W];
  assign rd = instr_in[11 +: REG_W];
  assign unused_instr = ^instr_in;

  always_comb begin
    rd_rs  = 1'b0;
    rd_rt  = 1'b0;
    wr_en  = 1'b0;
    is_ld  = 1'b0;
    wr_dst = '0;
    casez (op)
      6'b001???: begin rd_rs = 1'b1; wr_en = 1'b1; wr_dst = rt; end
      6'b100???: begin rd_rs = 1'b1; wr_en = 1'b1; wr_dst = rt; is_ld = 1'b1; end
      6'b00011?, 6'b000001: rd_rs = 1'b1;
      6'b1010??, 6'b00010?: begin rd_rs = 1'b1; rd_rt = 1'b1; end
      6'b000000: begin rd_rs = 1'b1; rd_rt = 1'b1; wr_en = 1'b1; wr_dst = rd; end
      6'b000011: begin wr_en = 1'b1; wr_dst = '1; end
      default: ;
    endcase
  end

  // With forwarding only a load still sitting in stage 0 can't be bypassed.
  always_comb begin
    rs_hit  = 1'b0;
    rt_hit  = 1'b0;
    tracked = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (FWD_EN == 0)
        tracked = (stage_dest[k] != '0);
      else
        tracked = (k == 0) && stage_ld[k] && (stage_dest[k] != '0);
      if (tracked && rd_rs && (rs != '0) && (rs == stage_dest[k])) rs_hit = 1'b1;
      if (tracked && rd_rt && (rt != '0) && (rt == stage_dest[k])) rt_hit = 1'b1;
    end
    stall_nxt = valid_in && (rs_hit || rt_hit);
    haz_nxt   = '0;
    if (stall_nxt) haz_nxt = rs_hit ? rs : rt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) stage_dest[k] <= '0;
      stage_ld        <= '0;
      stall_out       <= 1'b0;
      hazard_reg_out  <= '0;
      stall_count_out <= '0;
    end else begin
      if (stall_out && (stall_count_out != '1))
        stall_count_out <= stall_count_out + CNT_W'(1);
      if (flush_in) begin
        for (int k = 0; k < DEPTH; k++) stage_dest[k] <= '0;
        stage_ld       <= '0;
        stall_out      <= 1'b0;
        hazard_reg_out <= '0;
      end else begin
        for (int k = DEPTH - 1; k > 0; k--) begin
          stage_dest[k] <= stage_dest[k-1];
          stage_ld[k]   <= stage_ld[k-1];
        end
        if (!stall_nxt && valid_in && wr_en) begin
          stage_dest[0] <= wr_dst;
          stage_ld[0]   <= is_ld;
        end else begin
          stage_dest[0] <= '0;
          stage_ld[0]   <= 1'b0;
        end
        stall_out      <= stall_nxt;
        hazard_reg_out <= haz_nxt;
      end
    end
  end

endmodule
